// File: rtl/wb_grf.sv
// Writeback value select/extend plus 32x32 register file with W->D write-through.
// Optional build macro WB_GRF_TRACE_EN prints one trace line per committed write.
module wb_grf #(
  parameter int          NREG      = 32,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir_W,
  input  logic [31:0] pc_W,
  input  logic [31:0] ao_W,
  input  logic [31:0] dr_W,
  input  logic [31:0] hilo_W,
  input  logic [31:0] control_W,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [4:0]  wa_W,
  output logic [31:0] wd_W
);

  typedef enum logic [1:0] {
    WD_AO   = 2'd0,
    WD_LOAD = 2'd1,
    WD_PC8  = 2'd2,
    WD_HILO = 2'd3
  } wd_sel_e;

  typedef enum logic [1:0] {
    DST_RT   = 2'd0,
    DST_RD   = 2'd1,
    DST_RA   = 2'd2,
    DST_NONE = 2'd3
  } dst_sel_e;

  wd_sel_e     wd_sel;
  logic [2:0]  ld_type;
  logic        reg_we;
  dst_sel_e    dst_sel;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  logic [31:0] grf_q [NREG];

  logic unused_ok;
  assign unused_ok = ^{control_W[31:8], ir_W[31:21], ir_W[10:0]};

  assign wd_sel  = wd_sel_e'(control_W[1:0]);
  assign ld_type = control_W[4:2];
  assign reg_we  = control_W[5];
  assign dst_sel = dst_sel_e'(control_W[7:6]);

  // Byte lane picked by the low address bits; halfword lane by bit 1 only.
  assign ld_byte = dr_W[8*ao_W[1:0] +: 8];
  assign ld_half = ao_W[1] ? dr_W[31:16] : dr_W[15:0];

  always_comb begin
    case (ld_type)
      3'd1:    ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'd2:    ld_val = {24'h0, ld_byte};
      3'd3:    ld_val = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_val = {16'h0, ld_half};
      default: ld_val = dr_W;
    endcase
  end

  always_comb begin
    case (wd_sel)
      WD_AO:   wd_W = ao_W;
      WD_LOAD: wd_W = ld_val;
      WD_PC8:  wd_W = pc_W + 32'd8;
      WD_HILO: wd_W = hilo_W;
      default: wd_W = ao_W;
    endcase
  end

  always_comb begin
    wa_W = 5'd0;
    if (reg_we) begin
      case (dst_sel)
        DST_RT:  wa_W = ir_W[20:16];
        DST_RD:  wa_W = ir_W[15:11];
        DST_RA:  wa_W = 5'd31;
        default: wa_W = 5'd0;
      endcase
    end
  end

  // Entry 0 is never written; reads of $0 are forced to zero below.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) grf_q[i] <= RESET_VAL;
    end else if (wa_W != 5'd0 && int'(wa_W) < NREG) begin
      grf_q[wa_W] <= wd_W;
    end
  end

  // Bypass only while out of reset, since no write can commit during reset.
  always_comb begin
    rd1 = 32'h0;
    if (ra1 != 5'd0) begin
      if (reset && ra1 == wa_W)   rd1 = wd_W;
      else if (int'(ra1) < NREG)  rd1 = grf_q[ra1];
    end
  end

  always_comb begin
    rd2 = 32'h0;
    if (ra2 != 5'd0) begin
      if (reset && ra2 == wa_W)   rd2 = wd_W;
      else if (int'(ra2) < NREG)  rd2 = grf_q[ra2];
    end
  end

`ifdef WB_GRF_TRACE_EN
  always @(posedge clk) begin
    if (reset && wa_W != 5'd0)
      $display("%d@%h: $%d <= %h", $time, pc_W, wa_W, wd_W);
  end
`else
`endif

endmodule

// File: tb/tb_wb_grf.sv
// Directed self-checking bench for wb_grf: load extension, jal link, write-through,
// $0 handling, and asynchronous reset behaviour.
module tb_wb_grf;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir_W, pc_W, ao_W, dr_W, hilo_W, control_W;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1, rd2;
  logic [4:0]  wa_W;
  logic [31:0] wd_W;
  int tests = 0;
  int fails = 0;

  wb_grf dut (
    .clk(clk), .reset(reset), .ir_W(ir_W), .pc_W(pc_W), .ao_W(ao_W), .dr_W(dr_W),
    .hilo_W(hilo_W), .control_W(control_W), .ra1(ra1), .ra2(ra2),
    .rd1(rd1), .rd2(rd2), .wa_W(wa_W), .wd_W(wd_W)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ctl(input logic [1:0] wsel, input logic [2:0] ld,
                                      input logic we, input logic [1:0] dst);
    return {24'h0, dst, we, ld, wsel};
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] rt, input logic [4:0] rd);
    return {6'h0f, 5'h1a, rt, rd, 5'h0, 6'h21};
  endfunction

  task automatic bubble();
    ir_W = '0; pc_W = '0; ao_W = '0; dr_W = '0; hilo_W = '0; control_W = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bubble(); ra1 = 5'd5; ra2 = 5'd31;
    #2 reset = 1'b0;
    #1;
    tests++; if (rd1 !== 32'h0) begin fails++; $display("FAIL reset_rd1: got %h expected %h", rd1, 32'h0); end
    tests++; if (rd2 !== 32'h0) begin fails++; $display("FAIL reset_rd2: got %h expected %h", rd2, 32'h0); end
    tests++; if (wa_W !== 5'd0) begin fails++; $display("FAIL bubble_wa: got %0d expected 0", wa_W); end
    tests++; if (wd_W !== 32'h0) begin fails++; $display("FAIL bubble_wd: got %h expected %h", wd_W, 32'h0); end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_reset_hold();
    @(negedge clk);
    ir_W = mk_ir(5'd0, 5'd5); ao_W = 32'h1234; control_W = ctl(2'd0, 3'd0, 1'b1, 2'd1);
    @(posedge clk); #1 bubble(); ra1 = 5'd5; #1;
    tests++; if (rd1 !== 32'h1234) begin fails++; $display("FAIL hold_pre: got %h expected %h", rd1, 32'h1234); end
    @(negedge clk) reset = 1'b0;
    ao_W = 32'h9999; ir_W = mk_ir(5'd0, 5'd5); control_W = ctl(2'd0, 3'd0, 1'b1, 2'd1);
    #1;
    tests++; if (rd1 !== 32'h0) begin fails++; $display("FAIL hold_async: got %h expected %h", rd1, 32'h0); end
    tests++; if (wa_W !== 5'd5) begin fails++; $display("FAIL hold_wa: got %0d expected 5", wa_W); end
    tests++; if (wd_W !== 32'h9999) begin fails++; $display("FAIL hold_wd: got %h expected %h", wd_W, 32'h9999); end
    repeat (3) @(posedge clk);
    #1;
    tests++; if (rd1 !== 32'h0) begin fails++; $display("FAIL hold_nowrite: got %h expected %h", rd1, 32'h0); end
    @(negedge clk) bubble(); reset = 1'b1;
    #1;
    tests++; if (rd1 !== 32'h0) begin fails++; $display("FAIL hold_after: got %h expected %h", rd1, 32'h0); end
  endtask

  task automatic test_load();
    logic [31:0] exp_v [6];
    logic [2:0]  ld_v  [6];
    logic [31:0] ao_v  [6];
    ld_v[0] = 3'd1; ao_v[0] = 32'h0000_1003; exp_v[0] = 32'hFFFF_FF80;
    ld_v[1] = 3'd2; ao_v[1] = 32'h0000_1003; exp_v[1] = 32'h0000_0080;
    ld_v[2] = 3'd3; ao_v[2] = 32'h0000_1002; exp_v[2] = 32'hFFFF_80FF;
    ld_v[3] = 3'd4; ao_v[3] = 32'h0000_1003; exp_v[3] = 32'h0000_80FF;
    ld_v[4] = 3'd1; ao_v[4] = 32'h0000_1000; exp_v[4] = 32'h0000_0001;
    ld_v[5] = 3'd6; ao_v[5] = 32'h0000_1001; exp_v[5] = 32'h80FF_7F01;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dr_W = 32'h80FF_7F01; ao_W = ao_v[i]; ir_W = mk_ir(5'd8, 5'd3);
      control_W = ctl(2'd1, ld_v[i], 1'b1, 2'd0); ra1 = 5'd3; ra2 = 5'd0;
      #1;
      tests++; if (wd_W !== exp_v[i]) begin fails++; $display("FAIL load_wd[%0d]: got %h expected %h", i, wd_W, exp_v[i]); end
      tests++; if (wa_W !== 5'd8) begin fails++; $display("FAIL load_wa[%0d]: got %0d expected 8", i, wa_W); end
      @(posedge clk); #1 bubble(); ra1 = 5'd8; #1;
      tests++; if (rd1 !== exp_v[i]) begin fails++; $display("FAIL load_reg[%0d]: got %h expected %h", i, rd1, exp_v[i]); end
    end
  endtask

  task automatic test_jal();
    @(negedge clk);
    pc_W = 32'h0000_3000; ir_W = mk_ir(5'd4, 5'd6); control_W = ctl(2'd2, 3'd0, 1'b1, 2'd2);
    #1;
    tests++; if (wa_W !== 5'd31) begin fails++; $display("FAIL jal_wa: got %0d expected 31", wa_W); end
    tests++; if (wd_W !== 32'h0000_3008) begin fails++; $display("FAIL jal_wd: got %h expected %h", wd_W, 32'h0000_3008); end
    @(posedge clk); #1 bubble(); ra2 = 5'd31; #1;
    tests++; if (rd2 !== 32'h0000_3008) begin fails++; $display("FAIL jal_reg: got %h expected %h", rd2, 32'h0000_3008); end
    @(negedge clk);
    pc_W = 32'hFFFF_FFFC; control_W = ctl(2'd2, 3'd0, 1'b1, 2'd2);
    #1;
    tests++; if (wd_W !== 32'h0000_0004) begin fails++; $display("FAIL jal_wrap: got %h expected %h", wd_W, 32'h0000_0004); end
    @(posedge clk); #1 bubble(); ra2 = 5'd31; #1;
    tests++; if (rd2 !== 32'h0000_0004) begin fails++; $display("FAIL jal_wrap_reg: got %h expected %h", rd2, 32'h0000_0004); end
    @(negedge clk);
    hilo_W = 32'h0BAD_F00D; ir_W = mk_ir(5'd0, 5'd12); control_W = ctl(2'd3, 3'd0, 1'b1, 2'd1);
    #1;
    tests++; if (wd_W !== 32'h0BAD_F00D) begin fails++; $display("FAIL hilo_wd: got %h expected %h", wd_W, 32'h0BAD_F00D); end
    tests++; if (wa_W !== 5'd12) begin fails++; $display("FAIL hilo_wa: got %0d expected 12", wa_W); end
    @(posedge clk); #1 bubble();
  endtask

  task automatic test_write_through();
    @(negedge clk);
    ir_W = mk_ir(5'd0, 5'd9); ao_W = 32'h1111_1111; control_W = ctl(2'd0, 3'd0, 1'b1, 2'd1);
    @(posedge clk); #1 bubble(); ra1 = 5'd9; ra2 = 5'd9; #1;
    tests++; if (rd1 !== 32'h1111_1111) begin fails++; $display("FAIL wt_old: got %h expected %h", rd1, 32'h1111_1111); end
    @(negedge clk);
    ir_W = mk_ir(5'd0, 5'd9); ao_W = 32'hDEAD_BEEF; control_W = ctl(2'd0, 3'd0, 1'b1, 2'd1);
    #1;
    tests++; if (rd1 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wt_rd1: got %h expected %h", rd1, 32'hDEAD_BEEF); end
    tests++; if (rd2 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wt_rd2: got %h expected %h", rd2, 32'hDEAD_BEEF); end
    @(posedge clk); #1 bubble(); #1;
    tests++; if (rd1 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wt_stored: got %h expected %h", rd1, 32'hDEAD_BEEF); end
    @(negedge clk);
    ir_W = mk_ir(5'd9, 5'd9); ao_W = 32'h7777_7777; control_W = ctl(2'd0, 3'd0, 1'b1, 2'd3);
    #1;
    tests++; if (wa_W !== 5'd0) begin fails++; $display("FAIL nodst_wa: got %0d expected 0", wa_W); end
    tests++; if (rd1 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL nodst_rd: got %h expected %h", rd1, 32'hDEAD_BEEF); end
    @(posedge clk); #1 bubble(); #1;
    tests++; if (rd2 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL nodst_reg: got %h expected %h", rd2, 32'hDEAD_BEEF); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    ir_W = mk_ir(5'd0, 5'd0); ao_W = 32'h5; control_W = ctl(2'd0, 3'd0, 1'b1, 2'd1); ra1 = 5'd0;
    #1;
    tests++; if (wa_W !== 5'd0) begin fails++; $display("FAIL zero_wa: got %0d expected 0", wa_W); end
    tests++; if (rd1 !== 32'h0) begin fails++; $display("FAIL zero_rd_pre: got %h expected %h", rd1, 32'h0); end
    @(posedge clk); #1;
    tests++; if (rd1 !== 32'h0) begin fails++; $display("FAIL zero_rd_post: got %h expected %h", rd1, 32'h0); end
    tests++; if (wa_W !== 5'd0) begin fails++; $display("FAIL zero_wa_post: got %0d expected 0", wa_W); end
    @(negedge clk) bubble();
  endtask

  task automatic test_async_reset();
    logic [31:0] got;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      ir_W = mk_ir(5'(i), 5'd0); ao_W = 32'hA500_0000 + 32'(i); control_W = ctl(2'd0, 3'd0, 1'b1, 2'd0);
    end
    @(posedge clk); #1 bubble();
    for (int i = 1; i < 32; i++) begin
      ra1 = 5'(i); #1 got = rd1;
      tests++; if (got !== 32'hA500_0000 + 32'(i)) begin fails++; $display("FAIL fill[%0d]: got %h expected %h", i, got, 32'hA500_0000 + 32'(i)); end
    end
    @(negedge clk);
    ir_W = mk_ir(5'd4, 5'd0); ao_W = 32'hAAAA; control_W = ctl(2'd0, 3'd0, 1'b1, 2'd0);
    ra1 = 5'd4; ra2 = 5'd31;
    #2 reset = 1'b0;
    #1;
    tests++; if (rd1 !== 32'h0) begin fails++; $display("FAIL async_rd1: got %h expected %h", rd1, 32'h0); end
    tests++; if (rd2 !== 32'h0) begin fails++; $display("FAIL async_rd2: got %h expected %h", rd2, 32'h0); end
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    ir_W = mk_ir(5'd3, 5'd0); ao_W = 32'h55; control_W = ctl(2'd0, 3'd0, 1'b1, 2'd0);
    @(posedge clk); #1 bubble(); ra1 = 5'd3; ra2 = 5'd4; #1;
    tests++; if (rd1 !== 32'h55) begin fails++; $display("FAIL post_reset_wr: got %h expected %h", rd1, 32'h55); end
    tests++; if (rd2 !== 32'h0) begin fails++; $display("FAIL lost_write: got %h expected %h", rd2, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_reset_hold();
    test_load();
    test_jal();
    test_write_through();
    test_zero_reg();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish by 100000");
    $fatal(1, "timeout");
  end
endmodule
